regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two write-back requesters: requester 0 is the ALU result and requester 1 is the load/memory result. Arbitration is round-robin with valid/ready handshakes. The winning write is registered and presented to the register file's write_data/write_addr/write_enable one cycle later. A pending-write scoreboard (one bit per register) lets the decode stage detect read-after-write hazards on its two read addresses.

Parameters:
DATA_W, 8, width of register data
ADDR_W, 3, register address width; NREGS = 2**ADDR_W (8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req0_valid  in  1  ALU write-back request
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req0_ready  out  1  ALU request accepted this cycle (combinational)
req1_valid  in  1  load write-back request
req1_addr  in  ADDR_W  load destination register
req1_data  in  DATA_W  load data
req1_ready  out  1  load request accepted this cycle (combinational)
reserve_valid  in  1  decode issues an instruction that will write reserve_addr
reserve_addr  in  ADDR_W  register to mark pending
hz_addr0  in  ADDR_W  decode read address 0
hz_addr1  in  ADDR_W  decode read address 1
hazard  out  1  high if hz_addr0 or hz_addr1 is pending (combinational)
pending  out  NREGS  scoreboard bit vector, bit i means register i has an outstanding write
write_enable  out  1  to register file, registered
write_addr  out  ADDR_W  to register file, registered
write_data  out  DATA_W  to register file, registered

Behaviour:
- Reset (rst low, asynchronous): write_enable=0, write_addr=0, write_data=0, pending=0, and the round-robin pointer points to requester 0 (requester 0 has priority first).
- Arbitration (combinational, every cycle):
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by the pointer is granted.
  - Neither valid: no grant.
  - reqN_ready = grantN. A transfer occurs when valid and ready are both high.
- Pointer update:
  - After a grant while both requesters were valid, the pointer moves to the other requester.
  - With a single requester, the pointer is left unchanged.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1... There are no back-to-back grants to one side under contention.
- Output register: on the edge after a transfer, write_addr and write_data take the granted request's values.
  - write_enable=1, except when the granted addr==0. Register 0 is hardwired, so the request is accepted (ready=1) but write_enable=0.
  - With no transfer, write_enable=0 and write_addr/write_data hold their previous values.
- Latency: one cycle from the accepting edge to the write strobe. Throughput is one write per cycle.
- Scoreboard:
  - reserve_valid with reserve_addr!=0 sets pending[reserve_addr] on the next edge.
  - A transfer to addr A clears pending[A] on the same edge that loads the output register.
  - Reserve and clear of the same address on the same edge: set wins, because the new instruction owns the register.
  - pending[0] is never set.
- hazard = pending[hz_addr0] | pending[hz_addr1]. It reflects the registered state only and does not forward same-cycle reserves.
- Both requesters targeting the same address in the same cycle are serialized by arbitration. The first transfer clears the pending bit. The bench must not rely on ordering beyond the round-robin rule.
- A transfer to a non-pending register is legal: the write proceeds and pending stays 0.
- Reset asserted mid-operation: all state clears immediately, and any request not yet strobed is lost.

Test Plan:
1. Reset: drive rst=0 with random inputs → write_enable=0, pending=8'h00, req0_ready=1 once rst=1 with only req0 valid.
2. Single requester: req0 addr=3, data=8'hA5 for 1 cycle → next cycle write_enable=1, write_addr=3, write_data=8'hA5; the following cycle write_enable=0.
3. Contention: both valid for 4 cycles (req0 addr=1 data=8'h11, req1 addr=2 data=8'h22) → grant sequence 0,1,0,1; write_data sequence 11,22,11,22 each one cycle later.
4. Register 0 write: req1 addr=0 data=8'hFF → req1_ready=1, next cycle write_enable=0.
5. Scoreboard: reserve addr=5, then hz_addr0=5 → hazard=1 and pending=8'h20. Then req0 addr=5 → after the accepting edge, pending=0 and hazard=0.
6. Set-wins collision: pending[4]=1, same cycle reserve addr=4 and req1 transfer addr=4 → write_enable=1 to register 4, and pending[4] remains 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and load
// write-back paths, with a registered write strobe and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 3,
  localparam int NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              reserve_valid,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic [ADDR_W-1:0] hz_addr0,
  input  logic [ADDR_W-1:0] hz_addr1,
  output logic              hazard,
  output logic [NREGS-1:0]  pending,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data
);

  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } prio_e;

  prio_e             ptr_q, ptr_d;
  logic              write_enable_q, write_enable_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NREGS-1:0]  pending_q, pending_d;

  logic              grant0, grant1, xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant0    = req0_valid && (!req1_valid || (ptr_q == PRI_REQ0));
    grant1    = req1_valid && (!req0_valid || (ptr_q == PRI_REQ1));
    xfer      = grant0 || grant1;
    xfer_addr = grant1 ? req1_addr : req0_addr;
    xfer_data = grant1 ? req1_data : req0_data;

    // The pointer only moves under contention, so a lone requester never loses its turn.
    ptr_d = ptr_q;
    if (req0_valid && req1_valid) begin
      ptr_d = (ptr_q == PRI_REQ0) ? PRI_REQ1 : PRI_REQ0;
    end

    write_enable_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    if (xfer) begin
      write_addr_d   = xfer_addr;
      write_data_d   = xfer_data;
      write_enable_d = (xfer_addr != '0);
    end

    // Clear before set: a reserve landing with a retiring write to the same register wins.
    pending_d = pending_q;
    if (xfer) begin
      pending_d[xfer_addr] = 1'b0;
    end
    if (reserve_valid && (reserve_addr != '0)) begin
      pending_d[reserve_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q          <= PRI_REQ0;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      pending_q      <= '0;
    end else begin
      ptr_q          <= ptr_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      pending_q      <= pending_d;
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign hazard       = pending_q[hz_addr0] | pending_q[hz_addr1];
  assign pending      = pending_q;
  assign write_enable = write_enable_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corner cases, and
// randomized traffic against a queue-free behavioural model of the write port.
module tb_regfile_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid, req1_valid, reserve_valid;
  logic [2:0] req0_addr, req1_addr, reserve_addr, hz_addr0, hz_addr1;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, hazard, write_enable;
  logic [7:0] pending;
  logic [2:0] write_addr;
  logic [7:0] write_data;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .reserve_valid(reserve_valid),
    .reserve_addr (reserve_addr),
    .hz_addr0     (hz_addr0),
    .hz_addr1     (hz_addr1),
    .hazard       (hazard),
    .pending      (pending),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                       input logic rv, input logic [2:0] ra,
                       input logic [2:0] h0, input logic [2:0] h1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    reserve_valid = rv; reserve_addr = ra;
    hz_addr0 = h0; hz_addr1 = h1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: inputs held for one cycle, outputs observed in that same cycle
  // (registered outputs therefore reflect the previous row's transfer).
  typedef struct {
    logic       v0; logic [2:0] a0; logic [7:0] d0;
    logic       v1; logic [2:0] a1; logic [7:0] d1;
    logic       rv; logic [2:0] ra;
    logic [2:0] h0; logic [2:0] h1;
    logic       r0; logic r1; logic hz;
    logic       we; logic [2:0] wa; logic [7:0] wd;
    logic [7:0] pend;
  } vec_t;

  vec_t vecs[20];

  // Behavioural model: whose turn it is, which registers await a write,
  // and what the register file was last told.
  int       m_turn;
  bit       m_pend[8];
  bit       m_we;
  bit [2:0] m_wa;
  bit [7:0] m_wd;

  function automatic logic [7:0] model_pending();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    m_turn = 0;
    m_we   = 0;
    m_wa   = 0;
    m_wd   = 0;
    for (int i = 0; i < 8; i++) m_pend[i] = 0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with random traffic: registered outputs must stay cleared.
    for (int i = 0; i < 4; i++) begin
      drive($urandom_range(0, 1), 3'($urandom), 8'($urandom), $urandom_range(0, 1),
            3'($urandom), 8'($urandom), $urandom_range(0, 1), 3'($urandom),
            3'($urandom), 3'($urandom));
      #1;
      check($sformatf("rst%0d we", i), write_enable, 0);
      check($sformatf("rst%0d wa", i), write_addr, 0);
      check($sformatf("rst%0d wd", i), write_data, 0);
      check($sformatf("rst%0d pend", i), pending, 0);
      check($sformatf("rst%0d hz", i), hazard, 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    //          v0 a0 d0     v1 a1 d1     rv ra h0 h1  r0 r1 hz we wa wd     pend
    vecs[0]  = '{1, 3, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00};
    vecs[1]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 3, 8'hA5, 8'h00};
    vecs[2]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 3, 8'hA5, 8'h00};
    vecs[3]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, 1, 0, 0, 0, 3, 8'hA5, 8'h00};
    vecs[4]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, 0, 1, 0, 1, 1, 8'h11, 8'h00};
    vecs[5]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, 1, 0, 0, 1, 2, 8'h22, 8'h00};
    vecs[6]  = '{1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, 0, 1, 0, 1, 1, 8'h11, 8'h00};
    vecs[7]  = '{0, 0, 8'h00, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 1, 0, 1, 2, 8'h22, 8'h00};
    vecs[8]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF, 8'h00};
    vecs[9]  = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 5, 0, 0, 0, 0, 0, 0, 8'hFF, 8'h00};
    vecs[10] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 0, 0, 0, 1, 0, 0, 8'hFF, 8'h20};
    vecs[11] = '{1, 5, 8'h55, 0, 0, 8'h00, 0, 0, 5, 0, 1, 0, 1, 0, 0, 8'hFF, 8'h20};
    vecs[12] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 0, 0, 0, 0, 1, 5, 8'h55, 8'h00};
    vecs[13] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 4, 0, 4, 0, 0, 0, 0, 5, 8'h55, 8'h00};
    vecs[14] = '{0, 0, 8'h00, 1, 4, 8'h44, 1, 4, 0, 4, 0, 1, 1, 0, 5, 8'h55, 8'h10};
    vecs[15] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4, 0, 0, 1, 1, 4, 8'h44, 8'h10};
    vecs[16] = '{1, 4, 8'h99, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 4, 8'h44, 8'h10};
    vecs[17] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4, 0, 0, 0, 1, 4, 8'h99, 8'h00};
    vecs[18] = '{1, 6, 8'h66, 1, 7, 8'h77, 0, 0, 0, 0, 1, 0, 0, 0, 4, 8'h99, 8'h00};
    vecs[19] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 6, 8'h66, 8'h00};

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1,
            vecs[i].rv, vecs[i].ra, vecs[i].h0, vecs[i].h1);
      #1;
      check($sformatf("vec%0d r0", i), req0_ready, vecs[i].r0);
      check($sformatf("vec%0d r1", i), req1_ready, vecs[i].r1);
      check($sformatf("vec%0d hz", i), hazard, vecs[i].hz);
      check($sformatf("vec%0d we", i), write_enable, vecs[i].we);
      check($sformatf("vec%0d wa", i), write_addr, vecs[i].wa);
      check($sformatf("vec%0d wd", i), write_data, vecs[i].wd);
      check($sformatf("vec%0d pend", i), pending, vecs[i].pend);
      next_cycle();
    end

    // Mid-operation reset: a strobe and a pending bit in flight, then reset between edges.
    drive(1, 3, 8'hAA, 0, 0, 0, 1, 6, 6, 0);
    next_cycle();
    drive(0, 0, 0, 1, 7, 8'h77, 0, 0, 6, 0);
    #1;
    check("midrst pre we", write_enable, 1);
    check("midrst pre pend", pending, 8'h40);
    rst = 1'b0;
    #1;
    check("midrst we", write_enable, 0);
    check("midrst wa", write_addr, 0);
    check("midrst wd", write_data, 0);
    check("midrst pend", pending, 0);
    check("midrst hz", hazard, 0);
    next_cycle();
    check("midrst lost we", write_enable, 0);
    check("midrst lost wa", write_addr, 0);
    drive(1, 1, 8'h01, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("postrst r0", req0_ready, 1);
    check("postrst r1", req1_ready, 0);
    next_cycle();
    drive(1, 1, 8'h01, 1, 2, 8'h02, 0, 0, 0, 0);
    #1;
    check("postrst ptr r0", req0_ready, 1);
    check("postrst ptr r1", req1_ready, 0);
    check("postrst we", write_enable, 1);
    check("postrst wa", write_addr, 1);
    check("postrst wd", write_data, 8'h01);

    // Randomized traffic from a fresh reset against the model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 500; c++) begin
      int       g;
      bit [2:0] ga;
      bit [7:0] gd;
      drive($urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom),
            $urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom),
            $urandom_range(0, 1), 3'($urandom), 3'($urandom), 3'($urandom));
      #1;
      if (req0_valid && req1_valid) g = m_turn;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      else                          g = -1;
      check($sformatf("rnd%0d r0", c), req0_ready, g == 0);
      check($sformatf("rnd%0d r1", c), req1_ready, g == 1);
      check($sformatf("rnd%0d hz", c), hazard, m_pend[hz_addr0] || m_pend[hz_addr1]);
      check($sformatf("rnd%0d pend", c), pending, model_pending());
      check($sformatf("rnd%0d we", c), write_enable, m_we);
      check($sformatf("rnd%0d wa", c), write_addr, m_wa);
      check($sformatf("rnd%0d wd", c), write_data, m_wd);

      m_we = 0;
      if (g >= 0) begin
        ga = (g == 0) ? req0_addr : req1_addr;
        gd = (g == 0) ? req0_data : req1_data;
        m_wa = ga;
        m_wd = gd;
        m_we = (ga != 0);
        m_pend[ga] = 0;
      end
      if (reserve_valid && reserve_addr != 0) m_pend[reserve_addr] = 1;
      if (req0_valid && req1_valid) m_turn = 1 - m_turn;
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
